// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch front end. It owns the fetch PC and issues word requests
// to instruction memory. Returned instructions are kept in a small in-order
// queue together with their PCs, and the queue head is presented to decode.
// A redirect squashes every queued entry and every in-flight request. Stale
// responses that are still due from memory are counted in drop_cnt and are
// discarded as they arrive.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   redirect_valid/pc load a new fetch PC (pc[1:0] ignored), squash wrong path
//   hold              suppress new memory requests this cycle
//   pc_out            current fetch PC
//   imem_req_*        request channel (valid/ready, word-aligned byte address)
//   imem_rsp_*        in-order response channel, latency >= 1 cycle
//   if_valid/pc/inst  queue head offered to decode
//   id_ready          decode accepts the head
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        hold,
    output logic [31:0] pc_out,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        id_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] fill_q, fill_d;   // oldest allocated-but-unfilled slot
    logic [CW-1:0] count_q, count_d; // allocated slots
    logic [CW-1:0] unf_q, unf_d;     // allocated slots still awaiting data
    logic [CW-1:0] drop_q, drop_d;   // stale responses still to discard

    logic [31:0] pc_mem_q   [DEPTH];
    logic [31:0] inst_mem_q [DEPTH];

    logic req_fire;
    logic deq_fire;
    logic rsp_drop;
    logic rsp_store;

    assign imem_req_valid = !rst && !redirect_valid && !hold && (count_q < CW'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign pc_out         = fetch_pc_q;

    // Responses arrive in order, so the filled slots always form a contiguous
    // run starting at head; the head is filled exactly when some slot is.
    assign if_valid = !rst && !redirect_valid && (count_q != unf_q);
    assign if_pc    = pc_mem_q[head_q];
    assign if_inst  = inst_mem_q[head_q];

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign deq_fire  = if_valid && id_ready;
    assign rsp_drop  = imem_rsp_valid && (drop_q != '0);
    assign rsp_store = imem_rsp_valid && (drop_q == '0) && (unf_q != '0);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        fill_d     = fill_q;
        count_d    = count_q;
        unf_d      = unf_q;
        drop_d     = drop_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            head_d     = '0;
            tail_d     = '0;
            fill_d     = '0;
            count_d    = '0;
            unf_d      = '0;
            // Every still-unfilled slot has a response coming; a response
            // landing on this very edge already accounts for one of them.
            drop_d     = drop_q + unf_q - CW'(rsp_drop) - CW'(rsp_store);
        end else begin
            if (rsp_drop) begin
                drop_d = drop_q - CW'(1);
            end
            if (rsp_store) begin
                fill_d = fill_q + PW'(1);
            end
            if (req_fire) begin
                tail_d     = tail_q + PW'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (deq_fire) begin
                head_d = head_q + PW'(1);
            end
            unf_d   = unf_q + CW'(req_fire) - CW'(rsp_store);
            count_d = count_q + CW'(req_fire) - CW'(deq_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            unf_q      <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fill_q     <= fill_d;
            count_q    <= count_d;
            unf_q      <= unf_d;
            drop_q     <= drop_d;
        end
    end

    // Slot payload needs no reset: it is only observed once the control
    // state marks the slot filled.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pc_mem_q[tail_q] <= fetch_pc_q;
        end
        if (rsp_store && !redirect_valid) begin
            inst_mem_q[fill_q] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        hold;
    logic [31:0] pc_out;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        id_ready;

    if_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .hold           (hold),
        .pc_out         (pc_out),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .id_ready       (id_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          filled;
    } ent_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;

    // Reference model: fetch PC, ordered queue of fetched entries, stale count
    ent_t        mq[$];
    logic [31:0] m_pc;
    int          m_drop;
    // Memory model: pending responses in request order
    rsp_t        pend[$];
    int          lat_min = 1;
    int          lat_max = 1;
    int          cyc     = 0;

    int checks = 0;
    int errors = 0;

    logic        obs_req, obs_ifv;
    logic [31:0] obs_addr, obs_pcout, obs_ifpc;
    logic [31:0] dlv_pc[$];
    logic [31:0] dlv_inst[$];
    logic [31:0] hold_pc;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic int unfilled();
        int n = 0;
        foreach (mq[i]) if (!mq[i].filled) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive memory response, check outputs mid-cycle,
    // advance the model on the edge, return at the next falling edge.
    task automatic step();
        logic        e_req, e_ifv, dut_hs, pop, hs_m;
        logic [31:0] hs_addr;
        int          k, lat, due;
        ent_t        e;

        if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend[0].data;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        e_req = !rst && !redirect_valid && !hold && (mq.size() < DEPTH);
        e_ifv = !rst && !redirect_valid && (mq.size() > 0) && mq[0].filled;
        chk("req_valid", 32'(imem_req_valid), 32'(e_req));
        chk("req_addr", imem_req_addr, m_pc);
        chk("pc_out", pc_out, m_pc);
        chk("if_valid", 32'(if_valid), 32'(e_ifv));
        if (e_ifv) begin
            chk("if_pc", if_pc, mq[0].pc);
            chk("if_inst", if_inst, mq[0].inst);
        end
        obs_req   = imem_req_valid;
        obs_addr  = imem_req_addr;
        obs_pcout = pc_out;
        obs_ifv   = if_valid;
        obs_ifpc  = if_pc;
        if (if_valid && id_ready) begin
            dlv_pc.push_back(if_pc);
            dlv_inst.push_back(if_inst);
        end
        dut_hs  = imem_req_valid && imem_req_ready;
        hs_addr = imem_req_addr;

        @(posedge clk);
        if (rst) begin
            m_pc   = RST_PC;
            m_drop = 0;
            mq.delete();
            pend.delete();
        end else begin
            pop  = e_ifv && id_ready;
            hs_m = e_req && imem_req_ready;
            if (imem_rsp_valid) begin
                pend.delete(0);
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    k = -1;
                    foreach (mq[i]) if (k < 0 && !mq[i].filled) k = i;
                    if (k >= 0) begin
                        e        = mq[k];
                        e.inst   = imem_rsp_data;
                        e.filled = 1'b1;
                        mq[k]    = e;
                    end
                end
            end
            if (redirect_valid) begin
                m_drop += unfilled();
                mq.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (pop) mq.delete(0);
                if (hs_m) begin
                    e.pc     = m_pc;
                    e.inst   = 32'h0;
                    e.filled = 1'b0;
                    mq.push_back(e);
                    m_pc = m_pc + 32'd4;
                end
            end
            if (dut_hs) begin
                lat = $urandom_range(lat_max, lat_min);
                due = cyc + lat;
                if (pend.size() > 0 && pend[$].due + 1 > due) due = pend[$].due + 1;
                pend.push_back('{inst_of(hs_addr), due});
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        hold           = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic rand_inputs();
        rst            = ($urandom_range(199, 0) == 0);
        hold           = ($urandom_range(9, 0) == 0);
        imem_req_ready = ($urandom_range(3, 0) != 0);
        id_ready       = ($urandom_range(3, 0) != 0);
        redirect_pc    = $urandom;
        redirect_valid = ($urandom_range(11, 0) == 0) && (m_drop + unfilled() <= 2 * DEPTH - 1);
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        hold           = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        id_ready       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_pc   = RST_PC;
        m_drop = 0;

        // Reset state and streaming with 1-cycle memory, address wrap
        do_reset();
        dlv_pc.delete();
        step();
        chk("t1_c0_addr", obs_addr, RST_PC);
        chk("t1_c0_ifv", 32'(obs_ifv), 32'd0);
        step();
        chk("t1_c1_addr", obs_addr, 32'hFFFF_FFFC);
        chk("t1_c1_ifv", 32'(obs_ifv), 32'd0);
        step();
        chk("t1_c2_wrap_addr", obs_addr, 32'h0000_0000);
        chk("t1_c2_ifv", 32'(obs_ifv), 32'd1);
        chk("t1_c2_ifpc", obs_ifpc, RST_PC);
        repeat (10) step();
        chk("t1_dlv_n", 32'(dlv_pc.size()), 32'd11);
        for (int i = 0; i < 4; i++) chk("t1_dlv_order", dlv_pc[i], RST_PC + 32'(4 * i));

        // Decode backpressure: queue fills to DEPTH, then drains in order
        do_reset();
        id_ready = 1'b0;
        repeat (6) step();
        chk("t2_full_req", 32'(obs_req), 32'd0);
        chk("t2_full_ifv", 32'(obs_ifv), 32'd1);
        chk("t2_full_ifpc", obs_ifpc, RST_PC);
        dlv_pc.delete();
        id_ready = 1'b1;
        step();
        chk("t2_no_req_on_deq", 32'(obs_req), 32'd0);
        step();
        chk("t2_resume_req", 32'(obs_req), 32'd1);
        chk("t2_resume_addr", obs_addr, RST_PC + 32'h10);
        repeat (4) step();
        for (int i = 0; i < 4; i++) chk("t2_drain_order", dlv_pc[i], RST_PC + 32'(4 * i));

        // Redirect with two in-flight fetches, 3-cycle memory
        do_reset();
        lat_min = 3;
        lat_max = 3;
        repeat (2) step();
        dlv_pc.delete();
        dlv_inst.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        step();
        chk("t3_target_pc", obs_pcout, 32'h0000_0100);
        repeat (10) step();
        chk("t3_dlv_some", 32'(dlv_pc.size() > 0), 32'd1);
        chk("t3_first_pc", dlv_pc[0], 32'h0000_0100);
        chk("t3_first_inst", dlv_inst[0], 32'hA5A5_0100);

        // Redirect coinciding with a response and a ready head
        do_reset();
        lat_min = 1;
        lat_max = 1;
        repeat (6) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        chk("t4_redir_ifv", 32'(obs_ifv), 32'd0);
        redirect_valid = 1'b0;
        dlv_pc.delete();
        step();
        chk("t4_empty_after", 32'(obs_ifv), 32'd0);
        repeat (5) step();
        chk("t4_first_pc", dlv_pc[0], 32'h0000_0200);

        // hold for five cycles mid-stream
        repeat (4) step();
        hold = 1'b1;
        dlv_pc.delete();
        step();
        hold_pc = obs_pcout;
        chk("t5_hold_req", 32'(obs_req), 32'd0);
        repeat (4) begin
            step();
            chk("t5_hold_req", 32'(obs_req), 32'd0);
            chk("t5_hold_pc", obs_pcout, hold_pc);
        end
        chk("t5_dlv_in_hold", 32'(dlv_pc.size() > 0), 32'd1);
        hold = 1'b0;
        step();
        chk("t5_resume_req", 32'(obs_req), 32'd1);
        chk("t5_resume_addr", obs_addr, hold_pc);

        // Reset mid-stream
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("t6_rst_ifv", 32'(obs_ifv), 32'd0);
        chk("t6_rst_pc", obs_pcout, RST_PC);

        // Randomized traffic against the reference model
        lat_min = 1;
        lat_max = 4;
        repeat (2000) begin
            rand_inputs();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
